add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, 32, operand/result width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester N presents an operand pair.
REQ-006 req0_ready / req1_ready  output  1 each  requester N's pair is accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  two's-complement operands.
REQ-008 req0_cin / req1_cin  input  1 each  carry-in.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_ready  input  1  consumer accepts the result this cycle.
REQ-011 res_sum  output  WIDTH  registered a+b+cin, modulo 2^WIDTH.
REQ-012 res_cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 res_of  output  1  registered signed overflow.
REQ-014 res_id  output  1  requester that produced the result: 0 = req0, 1 = req1.

Function
REQ-015 Both requesters SHALL share one WIDTH-bit adder; at most one pair is accepted per cycle.
REQ-016 Transfers SHALL complete only when valid and ready are both high on a rising clk edge, on either side.
REQ-017 accept_en SHALL equal (!res_valid) | res_ready.
REQ-018 If only one requester is valid, that requester SHALL be granted.
REQ-019 If both are valid, the requester other than last_grant SHALL be granted (round-robin).
REQ-020 reqN_ready SHALL equal accept_en & grantN. The ready of the losing requester SHALL be 0.
REQ-021 reqN_ready MAY depend combinationally on req*_valid and res_ready.
REQ-022 last_grant SHALL update only on an accepted transfer.
REQ-023 Accepted results SHALL appear on res_* on the next cycle (latency 1), with res_valid = 1.
REQ-024 res_* SHALL hold stable while res_valid & !res_ready.
REQ-025 res_of SHALL equal (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1]), using the operands as presented.
REQ-026 Simultaneous drain and accept (res_valid & res_ready & a grant) SHALL load the new result with res_valid staying 1, giving full throughput with no bubble.
REQ-027 Drain with no grant SHALL clear res_valid.
REQ-028 A requester holding valid SHALL be granted within 2 accept_en cycles (no starvation).
REQ-029 Operand changes while reqN_valid & !reqN_ready SHALL have no effect.

Reset
REQ-030 On rst, outputs SHALL be: res_valid = 0, res_sum = 0, res_cout = 0, res_of = 0, res_id = 0, req0_ready = 0, req1_ready = 0.
REQ-031 On rst, last_grant SHALL be 1, so req0 wins the first contention.
REQ-032 Reset mid-operation SHALL discard any held result without emitting it.
REQ-033 The first acceptance after reset SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-034 A shared package/include SHALL hold the WIDTH default (32) and the ID_REQ0 = 0 and ID_REQ1 = 1 constants.
REQ-035 The adder SHALL be the existing CBA sub-module, instantiated once and purely combinationally, fed by the grant mux.
REQ-036 Arbitration and the result register SHALL live in add_arbiter; no other sub-modules SHALL be used.

Verification
REQ-037 Stimulus: req0 only, a = 7FFFFFFF, b = 7FFFFFFF, cin = 0. Response next cycle: res_sum = FFFFFFFE, cout = 0, of = 1, id = 0.
REQ-038 Stimulus: both valid after reset; req0 = 80000000 + FFFFFFFF, req1 = 12345678 + 12345670 with cin = 1. Response: req0 granted first (7FFFFFFF, cout = 1, of = 1), then req1 (2468ACE9, cout = 0, of = 0), on back-to-back cycles.
REQ-039 Stimulus: both valid continuously for 8 results with res_ready = 1. Response: res_id alternates 0,1,0,1…, res_valid stays high and there are no bubbles.
REQ-040 Stimulus: res_ready = 0 for 5 cycles with a result held (FFFFFFFF + FFFFFFFF). Response: res_sum stays FFFFFFFE, cout = 1, of = 0, and both readies are 0 throughout.
REQ-041 Stimulus: rst pulsed while res_valid = 1. Response: res_valid = 0 immediately, that result is never emitted, and the next contention grants req0.
REQ-042 Stimulus: req1 only, a = FFFFF999, b = 00000111. Response: res_sum = FFFFFAAA, cout = 0, of = 0, id = 1.

Source files
------------

// File: rtl/add_arbiter_pkg.sv
// rtl/add_arbiter_pkg.sv - shared width default and requester id constants
package add_arbiter_pkg;

  localparam int   DEF_WIDTH = 32;
  localparam logic ID_REQ0   = 1'b0;
  localparam logic ID_REQ1   = 1'b1;

endpackage

// File: rtl/add_arbiter_cba.sv
// rtl/add_arbiter_cba.sv - combinational carry-bypass adder, 4-bit bypass blocks
module add_arbiter_cba #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int BLK = 4;

  logic c;
  logic cb;
  logic cr;
  logic pall;
  logic p;

  // Each block ripples internally; when every bit propagates, the block's
  // carry-in bypasses straight to its carry-out.
  always_comb begin
    sum  = '0;
    c    = cin;
    cb   = 1'b0;
    cr   = 1'b0;
    pall = 1'b0;
    p    = 1'b0;
    for (int blk = 0; blk < WIDTH / BLK; blk++) begin
      cb   = c;
      cr   = c;
      pall = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        p                  = a[blk*BLK+j] ^ b[blk*BLK+j];
        sum[blk*BLK+j]     = p ^ cr;
        cr                 = (a[blk*BLK+j] & b[blk*BLK+j]) | (p & cr);
        pall               = pall & p;
      end
      c = pall ? cb : cr;
    end
    cout = c;
  end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - two-requester round-robin arbiter sharing one adder, registered result
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_of,
  output logic             res_id
);

  logic             last_grant;
  logic             accept_en;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             of;

  assign accept_en = !res_valid | res_ready;

  // On contention the requester that did not win last time goes next.
  assign grant0 = req0_valid & (!req1_valid | last_grant);
  assign grant1 = req1_valid & (!req0_valid | !last_grant);

  // Readies are forced low while reset is held so nothing looks accepted.
  assign req0_ready = accept_en & grant0 & !rst;
  assign req1_ready = accept_en & grant1 & !rst;
  assign accept     = req0_ready | req1_ready;

  assign op_a   = grant1 ? req1_a   : req0_a;
  assign op_b   = grant1 ? req1_b   : req0_b;
  assign op_cin = grant1 ? req1_cin : req0_cin;

  add_arbiter_cba #(.WIDTH(WIDTH)) u_cba (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (sum),
    .cout (cout)
  );

  assign of = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_of     <= 1'b0;
      res_id     <= ID_REQ0;
      last_grant <= ID_REQ1;
    end else if (accept) begin
      res_valid  <= 1'b1;
      res_sum    <= sum;
      res_cout   <= cout;
      res_of     <= of;
      res_id     <= grant1 ? ID_REQ1 : ID_REQ0;
      last_grant <= grant1 ? ID_REQ1 : ID_REQ0;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed self-checking bench for add_arbiter
module tb_add_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_sum;
  logic        res_cout, res_of, res_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_of(res_of), .res_id(res_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    step();
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    step();
    res_ready  = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst = 1'b1;
    #7;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
    total++; if (res_sum !== 32'h0) begin bad++; $display("FAIL rst_sum got=%h exp=00000000", res_sum); end
    total++; if (res_cout !== 1'b0) begin bad++; $display("FAIL rst_cout got=%b exp=0", res_cout); end
    total++; if (res_of !== 1'b0) begin bad++; $display("FAIL rst_of got=%b exp=0", res_of); end
    total++; if (res_id !== 1'b0) begin bad++; $display("FAIL rst_id got=%b exp=0", res_id); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_req0();
    req0_valid = 1'b1; req0_a = 32'h7FFFFFFF; req0_b = 32'h7FFFFFFF; req0_cin = 1'b0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL s0_ready0 got=%b exp=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL s0_ready1 got=%b exp=0", req1_ready); end
    step();
    req0_valid = 1'b0;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL s0_valid got=%b exp=1", res_valid); end
    total++; if (res_sum !== 32'hFFFFFFFE) begin bad++; $display("FAIL s0_sum got=%h exp=fffffffe", res_sum); end
    total++; if (res_cout !== 1'b0) begin bad++; $display("FAIL s0_cout got=%b exp=0", res_cout); end
    total++; if (res_of !== 1'b1) begin bad++; $display("FAIL s0_of got=%b exp=1", res_of); end
    total++; if (res_id !== 1'b0) begin bad++; $display("FAIL s0_id got=%b exp=0", res_id); end
    drain();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL s0_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_contention();
    pulse_reset();
    req0_valid = 1'b1; req0_a = 32'h80000000; req0_b = 32'hFFFFFFFF; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h12345678; req1_b = 32'h12345670; req1_cin = 1'b1;
    res_ready  = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL ct_ready0 got=%b exp=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL ct_ready1 got=%b exp=0", req1_ready); end
    step();
    req0_valid = 1'b0;
    total++; if (res_sum !== 32'h7FFFFFFF) begin bad++; $display("FAIL ct_sum0 got=%h exp=7fffffff", res_sum); end
    total++; if ({res_valid, res_cout, res_of, res_id} !== 4'b1110) begin bad++; $display("FAIL ct_flags0 got=%b exp=1110", {res_valid, res_cout, res_of, res_id}); end
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL ct_ready1b got=%b exp=1", req1_ready); end
    step();
    req1_valid = 1'b0;
    total++; if (res_sum !== 32'h2468ACE9) begin bad++; $display("FAIL ct_sum1 got=%h exp=2468ace9", res_sum); end
    total++; if ({res_valid, res_cout, res_of, res_id} !== 4'b1001) begin bad++; $display("FAIL ct_flags1 got=%b exp=1001", {res_valid, res_cout, res_of, res_id}); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;  req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_cin = 1'b0;
    res_ready  = 1'b1;
    exp_id = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, res_valid); end
      total++; if (res_id !== exp_id) begin bad++; $display("FAIL b2b_id[%0d] got=%b exp=%b", i, res_id, exp_id); end
      total++; if (res_sum !== (exp_id ? 32'd30 : 32'd3)) begin bad++; $display("FAIL b2b_sum[%0d] got=%0d exp=%0d", i, res_sum, exp_id ? 30 : 3); end
      exp_id = ~exp_id;
    end
    drain();
  endtask

  task automatic test_hold();
    req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF; req0_cin = 1'b0;
    res_ready  = 1'b0;
    step();
    req1_valid = 1'b1; req1_a = 32'h00000005; req1_b = 32'h00000006;
    for (int i = 0; i < 5; i++) begin
      req0_a = 32'h00000100 + i;
      #1;
      total++; if (res_sum !== 32'hFFFFFFFE) begin bad++; $display("FAIL hold_sum[%0d] got=%h exp=fffffffe", i, res_sum); end
      total++; if ({res_valid, res_cout, res_of} !== 3'b110) begin bad++; $display("FAIL hold_flags[%0d] got=%b exp=110", i, {res_valid, res_cout, res_of}); end
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); end
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_a = 32'h0000AAAA; req0_b = 32'h00001111; req0_cin = 1'b0;
    res_ready  = 1'b0;
    step();
    req0_valid = 1'b0;
    total++; if (res_sum !== 32'h0000BBBB) begin bad++; $display("FAIL rm_load got=%h exp=0000bbbb", res_sum); end
    rst = 1'b1;
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", res_valid); end
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h00000001; req0_b = 32'h00000001;
    req1_valid = 1'b1; req1_a = 32'h00000002; req1_b = 32'h00000002;
    res_ready  = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rm_grant got=%b exp=10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++; if ({res_valid, res_id} !== 2'b10) begin bad++; $display("FAIL rm_id got=%b exp=10", {res_valid, res_id}); end
    total++; if (res_sum !== 32'h00000002) begin bad++; $display("FAIL rm_sum got=%h exp=00000002", res_sum); end
    drain();
  endtask

  task automatic test_single_req1();
    req1_valid = 1'b1; req1_a = 32'hFFFFF999; req1_b = 32'h00000111; req1_cin = 1'b0;
    res_ready  = 1'b0;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL s1_ready got=%b exp=01", {req0_ready, req1_ready}); end
    step();
    req1_valid = 1'b0;
    total++; if (res_sum !== 32'hFFFFFAAA) begin bad++; $display("FAIL s1_sum got=%h exp=fffffaaa", res_sum); end
    total++; if ({res_valid, res_cout, res_of, res_id} !== 4'b1001) begin bad++; $display("FAIL s1_flags got=%b exp=1001", {res_valid, res_cout, res_of, res_id}); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_contention();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_single_req1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
